// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: FSM state encodings, stall-vector
// patterns and the stall priority helper.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MULTI   = 2'd1,
    ST_FLUSHED = 2'd2
  } pipe_state_e;

  // Hold vector bit order: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB.
  localparam logic [5:0] STALL_NONE      = 6'b000000;
  localparam logic [5:0] STALL_IF        = 6'b000011;
  localparam logic [5:0] STALL_ID        = 6'b000111;
  localparam logic [5:0] STALL_EX        = 6'b001111;
  localparam logic [5:0] STALL_MEM       = 6'b011111;
  localparam logic [5:0] STALL_KEEP_MASK = 6'b111000;

  function automatic logic [5:0] stall_pattern(input logic mem_req, input logic ex_req,
                                               input logic id_req, input logic if_req);
    if (mem_req)     return STALL_MEM;
    else if (ex_req) return STALL_EX;
    else if (id_req) return STALL_ID;
    else if (if_req) return STALL_IF;
    else             return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating performance counters for the pipeline controller (stalled cycles and
// flush pulses); only instantiated when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_any,
  input  logic        flush_pulse,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_any && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_pulse && (flush_count != '1))
        flush_count <= flush_count + 32'd1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall priority, multi-cycle EX sequencing and branch
// redirect/flush. Optional performance counters under macro PIPE_CTRL_PERF_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MULTI_CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stallreq_if,
  input  logic                   stallreq_id,
  input  logic                   stallreq_mem,
  input  logic                   ex_multi_start,
  input  logic [MULTI_CNT_W-1:0] ex_multi_cycles,
  input  logic                   branch_flag,
  input  logic [31:0]            branch_target,
  output logic [5:0]             stall,
  output logic                   flush,
  output logic                   redirect_valid,
  output logic [31:0]            redirect_pc,
  output logic                   ex_multi_done,
  output pipe_state_e            dbg_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_flush_count
`endif
);

  pipe_state_e            state_q, state_d;
  logic [MULTI_CNT_W-1:0] cnt_q, cnt_d;
  logic                   multi_start_ok;
  logic                   multi_stall;
  logic                   id_req;
  logic                   take_branch;

  // redirect_valid is a one-cycle strobe with no ready: the PC must load
  // redirect_pc in that same cycle. flush accompanies it unconditionally.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    flush          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    ex_multi_done  = 1'b0;

    multi_start_ok = ex_multi_start && (state_q != ST_MULTI);
    multi_stall    = multi_start_ok || (state_q == ST_MULTI);
    // The load-use request seen right after a flush belongs to a squashed instruction.
    id_req         = stallreq_id && (state_q != ST_FLUSHED);
    take_branch    = branch_flag && !stallreq_mem && !multi_stall;
    stall          = stall_pattern(stallreq_mem, multi_stall, id_req, stallreq_if);

    case (state_q)
      ST_MULTI: begin
        if (!stallreq_mem) begin
          if (cnt_q == '0) begin
            ex_multi_done = 1'b1;
            state_d       = ST_RUN;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
        if (multi_start_ok) begin
          // The start cycle is the first stalled cycle, so MULTI runs N-1 more.
          if (ex_multi_cycles > MULTI_CNT_W'(1)) begin
            cnt_d   = ex_multi_cycles - MULTI_CNT_W'(2);
            state_d = ST_MULTI;
          end else begin
            ex_multi_done = 1'b1;
          end
        end else if (take_branch) begin
          flush          = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = branch_target;
          stall          = stall & STALL_KEEP_MASK;
          state_d        = ST_FLUSHED;
        end
      end
    endcase

    if (!rst) begin
      stall          = STALL_NONE;
      flush          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      ex_multi_done  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dbg_state = state_q;

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk          (clk),
    .rst          (rst),
    .stall_any    (stall != STALL_NONE),
    .flush_pulse  (flush),
    .stall_cycles (perf_stall_cycles),
    .flush_count  (perf_flush_count)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed cycle tables plus a random stall-priority
// sweep; expected outputs flow through a scoreboard queue.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int W = 41;
  localparam logic [31:0] T1 = 32'h0000_1000;
  localparam logic [31:0] T2 = 32'hDEAD_BEE0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_if = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_mem = 1'b0;
  logic        ex_multi_start = 1'b0;
  logic [3:0]  ex_multi_cycles = 4'd0;
  logic        branch_flag = 1'b0;
  logic [31:0] branch_target = 32'd0;
  logic [5:0]  stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ex_multi_done;
  pipe_state_e dbg_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flush_count;
`endif

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_stall_cnt = 0;
  int exp_flush_cnt = 0;

  pipe_ctrl #(.MULTI_CNT_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .stallreq_if     (stallreq_if),
    .stallreq_id     (stallreq_id),
    .stallreq_mem    (stallreq_mem),
    .ex_multi_start  (ex_multi_start),
    .ex_multi_cycles (ex_multi_cycles),
    .branch_flag     (branch_flag),
    .branch_target   (branch_target),
    .stall           (stall),
    .flush           (flush),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .ex_multi_done   (ex_multi_done),
    .dbg_state       (dbg_state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (fields: stall[40:35] flush[34] rv[33] pc[32:1] done[0])",
               tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ev(input logic [5:0] s, input logic f, input logic rv,
                                      input logic [31:0] pc, input logic d);
    return {s, f, rv, pc, d};
  endfunction

  // driver: apply one cycle of inputs at negedge, compare mid-cycle, advance to next negedge
  task automatic cyc(input string tag, input logic r, input logic m, input logic ms,
                     input logic [3:0] n, input logic id, input logic fi, input logic br,
                     input logic [31:0] tgt, input logic [W-1:0] e);
    logic [W-1:0] got;
    rst = r; stallreq_mem = m; ex_multi_start = ms; ex_multi_cycles = n;
    stallreq_id = id; stallreq_if = fi; branch_flag = br; branch_target = tgt;
    exp_q.push_back(e);
    if (!r) begin
      exp_stall_cnt = 0;
      exp_flush_cnt = 0;
    end else begin
      if (e[40:35] != 6'd0) exp_stall_cnt++;
      if (e[34]) exp_flush_cnt++;
    end
    #1;
    got = {stall, flush, redirect_valid, redirect_pc, ex_multi_done};
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      check(tag, got, exp_q.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1, 0, 0, 0, 0, 0, 0, 32'd0, ev(6'b000000, 0, 0, 32'd0, 0));
  endtask

  task automatic check_state(input string tag, input logic [1:0] exp);
    check(tag, {{(W-2){1'b0}}, dbg_state}, {{(W-2){1'b0}}, exp});
  endtask

`ifdef PIPE_CTRL_PERF_EN
  task automatic check_perf(input string tag);
    check({tag, "_pstall"}, {9'd0, perf_stall_cycles}, {9'd0, 32'(exp_stall_cnt)});
    check({tag, "_pflush"}, {9'd0, perf_flush_count}, {9'd0, 32'(exp_flush_cnt)});
  endtask
`endif

  initial begin
    logic m, id, fi;
    logic [5:0] es;
    @(negedge clk);

    // reset holds all outputs low even with every request active
    cyc("rst_a", 0, 1, 1, 4'd5, 1, 1, 1, T1, ev(6'b000000, 0, 0, 32'd0, 0));
    cyc("rst_b", 0, 0, 0, 4'd0, 0, 0, 1, T1, ev(6'b000000, 0, 0, 32'd0, 0));
    check_state("rst_state", 2'd0);
`ifdef PIPE_CTRL_PERF_EN
    check_perf("rst");
`endif
    idle("idle0");

    // stall priority
    cyc("id_only", 1, 0, 0, 4'd0, 1, 0, 0, 32'd0, ev(6'b000111, 0, 0, 32'd0, 0));
    idle("id_clear");
    cyc("if_only", 1, 0, 0, 4'd0, 0, 1, 0, 32'd0, ev(6'b000011, 0, 0, 32'd0, 0));
    cyc("if_id", 1, 0, 0, 4'd0, 1, 1, 0, 32'd0, ev(6'b000111, 0, 0, 32'd0, 0));
    cyc("mem_all", 1, 1, 0, 4'd0, 1, 1, 0, 32'd0, ev(6'b011111, 0, 0, 32'd0, 0));
    idle("idle1");

    // N=5: five stalled cycles, done on the fifth; start during MULTI ignored
    cyc("m5_c1", 1, 0, 1, 4'd5, 0, 0, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 0));
    check_state("m5_state", 2'd1);
    cyc("m5_c2", 1, 0, 0, 4'd0, 1, 0, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 0));
    cyc("m5_c3", 1, 0, 1, 4'd2, 0, 0, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 0));
    cyc("m5_c4", 1, 0, 0, 4'd0, 0, 1, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 0));
    cyc("m5_c5", 1, 0, 0, 4'd0, 0, 0, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 1));
    idle("m5_after");

    // N=4 with two MEM-held cycles in the middle: six stalled cycles
    cyc("m4_c1", 1, 0, 1, 4'd4, 0, 0, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 0));
    cyc("m4_c2", 1, 0, 0, 4'd0, 0, 0, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 0));
    cyc("m4_mem1", 1, 1, 0, 4'd0, 0, 0, 0, 32'd0, ev(6'b011111, 0, 0, 32'd0, 0));
    cyc("m4_mem2", 1, 1, 0, 4'd0, 0, 0, 0, 32'd0, ev(6'b011111, 0, 0, 32'd0, 0));
    cyc("m4_c5", 1, 0, 0, 4'd0, 0, 0, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 0));
    cyc("m4_c6", 1, 0, 0, 4'd0, 0, 0, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 1));
    idle("m4_after");

    // short ops: N=2 one MULTI cycle; N=1 and N=0 stall only the start cycle
    cyc("m2_c1", 1, 0, 1, 4'd2, 0, 0, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 0));
    cyc("m2_c2", 1, 0, 0, 4'd0, 0, 0, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 1));
    idle("m2_after");
    cyc("m1_c1", 1, 0, 1, 4'd1, 0, 0, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 1));
    idle("m1_after");
    cyc("m0_c1", 1, 0, 1, 4'd0, 0, 0, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 1));
    idle("m0_after");

    // branch with load-use: flush, redirect, stall cleared; stale hazard masked once
    cyc("br_id", 1, 0, 0, 4'd0, 1, 0, 1, T1, ev(6'b000000, 1, 1, T1, 0));
    check_state("br_state", 2'd2);
    cyc("fl_id", 1, 0, 0, 4'd0, 1, 0, 0, 32'd0, ev(6'b000000, 0, 0, 32'd0, 0));
    cyc("run_id", 1, 0, 0, 4'd0, 1, 0, 0, 32'd0, ev(6'b000111, 0, 0, 32'd0, 0));
    idle("idle2");

    // fetch stall is not masked after a flush; branch inside FLUSHED is honoured
    cyc("br_if", 1, 0, 0, 4'd0, 0, 1, 1, T2, ev(6'b000000, 1, 1, T2, 0));
    cyc("fl_if", 1, 0, 0, 4'd0, 0, 1, 0, 32'd0, ev(6'b000011, 0, 0, 32'd0, 0));
    idle("idle3");
    cyc("br_a", 1, 0, 0, 4'd0, 0, 0, 1, T1, ev(6'b000000, 1, 1, T1, 0));
    cyc("br_b_fl", 1, 0, 0, 4'd0, 1, 0, 1, T2, ev(6'b000000, 1, 1, T2, 0));
    cyc("fl2_id", 1, 0, 0, 4'd0, 1, 0, 0, 32'd0, ev(6'b000000, 0, 0, 32'd0, 0));
    idle("idle4");

    // branch deferred behind a MEM stall
    cyc("br_mem", 1, 1, 0, 4'd0, 0, 0, 1, T1, ev(6'b011111, 0, 0, 32'd0, 0));
    cyc("br_mem_go", 1, 0, 0, 4'd0, 0, 0, 1, T1, ev(6'b000000, 1, 1, T1, 0));
    idle("idle5");

    // branch deferred behind an N=3 multi-cycle op, taken the cycle after done
    cyc("mb_c1", 1, 0, 1, 4'd3, 0, 0, 1, T2, ev(6'b001111, 0, 0, 32'd0, 0));
    cyc("mb_c2", 1, 0, 0, 4'd0, 0, 0, 1, T2, ev(6'b001111, 0, 0, 32'd0, 0));
    cyc("mb_c3", 1, 0, 0, 4'd0, 0, 0, 1, T2, ev(6'b001111, 0, 0, 32'd0, 1));
    cyc("mb_go", 1, 0, 0, 4'd0, 0, 0, 1, T2, ev(6'b000000, 1, 1, T2, 0));
    idle("idle6");
    idle("idle7");

    // random stall-request sweep in RUN
    for (int i = 0; i < 24; i++) begin
      m  = 1'($urandom_range(0, 1));
      id = 1'($urandom_range(0, 1));
      fi = 1'($urandom_range(0, 1));
      es = m ? 6'b011111 : id ? 6'b000111 : fi ? 6'b000011 : 6'b000000;
      cyc("rand", 1, m, 0, 4'd0, id, fi, 0, 32'd0, ev(es, 0, 0, 32'd0, 0));
    end
    idle("idle8");
`ifdef PIPE_CTRL_PERF_EN
    check_perf("run");
`endif

    // reset in the second cycle of MULTI: no done pulse, controller back in RUN
    cyc("rm_c1", 1, 0, 1, 4'd5, 0, 0, 0, 32'd0, ev(6'b001111, 0, 0, 32'd0, 0));
    cyc("rm_rst", 0, 0, 0, 4'd0, 0, 0, 0, 32'd0, ev(6'b000000, 0, 0, 32'd0, 0));
    check_state("rm_state", 2'd0);
`ifdef PIPE_CTRL_PERF_EN
    check_perf("rm");
`endif
    idle("rm_c3");
    idle("rm_c4");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
